rot_issue_queue: RTL and testbench
==================================

Name: rot_issue_queue

Overview:
- Upstream issue stage for the 32-bit combinational rotate-right unit.
- Buffers rotate requests (data, amount, direction) in a small FIFO with a valid/ready input handshake.
- Converts left-rotate requests to the equivalent right-rotate amount, presents the FIFO head to the rotator, and registers the rotator result into an output slot with a valid/ready output handshake.
- Keeps the rotator purely combinational while the datapath sustains one rotation per cycle under backpressure.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  queue can accept a request.
- in_data  input  32  data to rotate.
- in_amount  input  5  rotation amount, 0-31.
- in_left  input  1  1 = rotate left, 0 = rotate right.
- rot_data  output  32  head data driven to the rotator's input_data.
- rot_amount  output  5  head right-rotate amount driven to the rotator's rot_amount.
- rot_result  input  32  rotator output_data, returned combinationally.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  registered rotation result.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - wr_ptr, rd_ptr and count clear to 0.
  - out_valid = 0 and out_data = 0.
  - in_ready = 1 once reset deasserts.
  - FIFO storage is not reset.
  - An in-flight request or a held result is discarded.
- Push:
  - in_ready = (count != DEPTH), combinational from count only. There is no full-queue bypass: in_ready stays 0 when full even if a pop occurs in the same cycle.
  - Push occurs when in_valid && in_ready.
  - Storage per entry is {in_data, amount_r}. amount_r = in_left ? (32 - in_amount) mod 32 : in_amount, a 5-bit wrap, so left 0 maps to right 0.
  - wr_ptr increments modulo DEPTH.
- Head presentation:
  - rot_data = mem[rd_ptr] and rot_amount = stored amount_r[rd_ptr], driven combinationally from the registers.
  - When count == 0, rot_data and rot_amount still show mem[rd_ptr] (don't-care); the block ignores rot_result in that case.
- Pop / output load:
  - The output slot can load when !out_valid || out_ready.
  - Pop occurs when count != 0 and the slot can load. On pop: out_data <= rot_result, out_valid <= 1, and rd_ptr increments modulo DEPTH.
  - If out_valid && out_ready and there is no pop: out_valid <= 0, and out_data holds its last value.
  - While out_valid && !out_ready: out_data and out_valid are held stable.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Simultaneous push and pop is legal at any count below DEPTH, including count == 0 followed by a pop on the next cycle.
- Latency and throughput:
  - A request accepted at edge E into an empty queue with an empty output slot gives out_valid = 1 after edge E+1.
  - With out_ready held at 1, throughput is 1 result per cycle.
- Capacity:
  - DEPTH entries in the FIFO plus 1 in the output slot.
  - Results leave in strict FIFO order.

Optional Feature:
- Macro: ROT_ISSUE_STATS_EN.
- When defined:
  - Adds output port stat_done, 16 bits.
  - Increments on every output handshake (out_valid && out_ready).
  - Saturates at 0xFFFF and clears to 0 on rst.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Basic right rotate:
  - Stimulus: reset, out_ready = 1, push in_data = 0x12345678, in_amount = 4, in_left = 0.
  - Required: rot_amount = 4 while the request is at the head; out_data = 0x81234567 with out_valid = 1 one edge after acceptance.
- Left conversion:
  - Stimulus: push 0x12345678, in_amount = 8, in_left = 1.
  - Required: rot_amount = 24 and out_data = 0x34567812.
- Left 0 / right 0:
  - Stimulus: push 0xDEADBEEF with in_amount = 0, once with in_left = 1 and once with in_left = 0.
  - Required: both give rot_amount = 0 and out_data = 0xDEADBEEF.
- Backpressure fill:
  - Stimulus: out_ready = 0, push 6 requests back to back, with data 1..6 each rotated right by 1.
  - Required:
    - 5 requests are accepted; in_ready = 0 on the 6th.
    - out_data = 0x80000000 is held stable.
    - Raising out_ready drains 0x80000000, 0x00000001, 0x80000001, 0x00000002, 0x80000002, 0x00000003 in order, one per cycle.
- Streaming with simultaneous push/pop:
  - Stimulus: out_ready = 1, in_valid = 1 for 20 cycles.
  - Required: count stays at or below 1, in_ready stays 1, and 20 ordered results are produced.
- Mid-operation reset:
  - Stimulus: with 3 entries queued and out_valid = 1, assert rst between clock edges.
  - Required: out_valid = 0 and in_ready = 1 immediately; no stale result appears after release.
  - With ROT_ISSUE_STATS_EN defined, stat_done = 0.

Source files
------------

// File: rtl/rot_issue_queue.sv
// Issue queue in front of the 32-bit combinational rotate-right unit: FIFO of requests, left-to-right
// amount conversion, and a registered result slot. Optional macro ROT_ISSUE_STATS_EN adds a
// 16-bit saturating count of output handshakes on port stat_done.
module rot_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_amount,
  input  logic        in_left,
  output logic [31:0] rot_data,
  output logic [4:0]  rot_amount,
  input  logic [31:0] rot_result,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef ROT_ISSUE_STATS_EN
  output logic [31:0] out_data,
  output logic [15:0] stat_done
`else
  output logic [31:0] out_data
`endif
);

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  // A left rotate by n equals a right rotate by (32 - n) mod 32, i.e. the 5-bit negation.
  function automatic logic [4:0] to_right_amount(input logic [4:0] amount, input logic left);
    if (left) begin
      return 5'd0 - amount;
    end else begin
      return amount;
    end
  endfunction

  logic [31:0]   data_mem_r [DEPTH];
  logic [4:0]    amt_mem_r  [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;
  logic          slot_free_s;

  assign in_ready    = (count_r != FULL_CNT);
  assign push_s      = in_valid && in_ready;
  assign slot_free_s = !out_valid || out_ready;
  assign pop_s       = (count_r != {(AW+1){1'b0}}) && slot_free_s;
  assign rot_data    = data_mem_r[rd_ptr_r];
  assign rot_amount  = amt_mem_r[rd_ptr_r];

  // Entry storage: written on push, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= in_data;
      amt_mem_r[wr_ptr_r]  <= to_right_amount(in_amount, in_left);
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output slot captures the rotator result for the head entry when it pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
    end else if (pop_s) begin
      out_valid <= 1'b1;
      out_data  <= rot_result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef ROT_ISSUE_STATS_EN
  // Saturating count of completed output handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done <= 16'd0;
    end else if (out_valid && out_ready && (stat_done != 16'hFFFF)) begin
      stat_done <= stat_done + 16'd1;
    end else begin
      stat_done <= stat_done;
    end
  end
`endif

endmodule

// File: tb/tb_rot_issue_queue.sv
// Directed bench for rot_issue_queue with a queue-based reference model and per-cycle compare.
module tb_rot_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_amount = 5'd0;
  logic        in_left = 1'b0;
  logic [31:0] rot_data;
  logic [4:0]  rot_amount;
  logic [31:0] rot_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef ROT_ISSUE_STATS_EN
  logic [15:0] stat_done;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rot_issue_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amount(in_amount), .in_left(in_left),
    .rot_data(rot_data), .rot_amount(rot_amount), .rot_result(rot_result),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef ROT_ISSUE_STATS_EN
    .out_data(out_data), .stat_done(stat_done)
`else
    .out_data(out_data)
`endif
  );

  // Stand-in for the combinational rotator.
  assign rot_result = (rot_amount == 5'd0) ? rot_data :
                      ((rot_data >> rot_amount) | (rot_data << (6'd32 - {1'b0, rot_amount})));

  function automatic logic [31:0] ror(input logic [31:0] d, input int a);
    logic [63:0] t;
    t = {d, d} >> a;
    return t[31:0];
  endfunction

  function automatic int right_amt(input int a, input bit left);
    return left ? (32 - a) % 32 : a;
  endfunction

  typedef struct { logic [31:0] d; int a; } ent_t;
  ent_t        mq[$];
  bit          m_ov = 1'b0;
  logic [31:0] m_od = 32'd0;
  int          m_stat = 0;
  bit          cmp_on = 1'b0;
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          cyc = 0;
  bit          last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_od = 32'd0;
    m_stat = 0;
  endtask

  // One clock: decide push/pop from the queue rules, then advance the model after the edge.
  task automatic tick();
    bit push, pop, hs;
    push = in_valid && (mq.size() != DEPTH);
    pop  = (mq.size() != 0) && (!m_ov || out_ready);
    hs   = out_valid && out_ready;
    if (hs) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_ov && out_ready && m_stat != 16'hFFFF) m_stat++;
    if (pop) begin
      m_od = ror(mq[0].d, mq[0].a);
      m_ov = 1'b1;
      void'(mq.pop_front());
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (push) mq.push_back('{in_data, right_amt(int'(in_amount), in_left)});
    last_push = push;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input int a, input bit l);
    in_valid = v;
    in_data = d;
    in_amount = a[4:0];
    in_left = l;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("out_data", out_data, m_od);
      if (mq.size() != 0) begin
        chk("rot_data", rot_data, mq[0].d);
        chk("rot_amount", {27'd0, rot_amount}, mq[0].a);
      end
`ifdef ROT_ISSUE_STATS_EN
      chk("stat_done", {16'd0, stat_done}, m_stat);
`endif
    end
  end

  initial begin
    logic [31:0] exp_drain [6];
    logic [31:0] exp_stream[$];
    logic [31:0] d;
    int a;
    bit l;
    int n;

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // Basic right rotate and its latency.
    out_ready = 1'b1;
    drive(1'b1, 32'h12345678, 4, 1'b0);
    tick();
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("basic_rot_amount", {27'd0, rot_amount}, 32'd4);
    chk("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_out_data", out_data, 32'h81234567);
    tick();

    // Left conversion.
    drive(1'b1, 32'h12345678, 8, 1'b1);
    tick();
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("left_rot_amount", {27'd0, rot_amount}, 32'd24);
    tick();
    chk("left_out_data", out_data, 32'h34567812);
    tick();

    // Left 0 and right 0.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hDEADBEEF, 0, k == 0);
      tick();
      drive(1'b0, 32'd0, 0, 1'b0);
      chk("zero_rot_amount", {27'd0, rot_amount}, 32'd0);
      tick();
      chk("zero_out_data", out_data, 32'hDEADBEEF);
      tick();
    end

    // Backpressure fill: 5 accepted, 6th waits.
    out_ready = 1'b0;
    got_q.delete();
    got_cyc.delete();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, i, 1, 1'b0);
      chk("fill_in_ready", {31'd0, in_ready}, {31'd0, i <= 5});
      if (i <= 5) tick();
    end
    repeat (3) tick();
    chk("fill_held_data", out_data, 32'h80000000);
    chk("fill_held_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    n = 0;
    while (got_q.size() < 6 && n < 20) begin
      tick();
      if (last_push) drive(1'b0, 32'd0, 0, 1'b0);
      n++;
    end
    drive(1'b0, 32'd0, 0, 1'b0);
    exp_drain = '{32'h80000000, 32'h00000001, 32'h80000001,
                  32'h00000002, 32'h80000002, 32'h00000003};
    chk("drain_count", got_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      chk("drain_order", got_q[i], exp_drain[i]);
      if (i > 0) chk("drain_back_to_back", got_cyc[i] - got_cyc[i-1], 32'd1);
    end
    repeat (2) tick();

    // Streaming with simultaneous push and pop.
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      d = 32'hA5000000 ^ (i * 32'h00010203);
      a = (i * 7) % 32;
      l = i[0];
      exp_stream.push_back(ror(d, right_amt(a, l)));
      drive(1'b1, d, a, l);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b0, 32'd0, 0, 1'b0);
    repeat (4) tick();
    chk("stream_count", got_q.size(), 32'd20);
    for (int i = 0; i < 20 && i < got_q.size(); i++) chk("stream_order", got_q[i], exp_stream[i]);

    // Mid-operation reset with 3 queued entries and a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0DE0000 + i, i, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_reset_full", {31'd0, in_ready}, 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_now_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_now_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ROT_ISSUE_STATS_EN
    chk("reset_now_stat", {16'd0, stat_done}, 32'd0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    repeat (5) tick();
    chk("no_stale_result", got_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
